// File: rtl/tp_dr_rx.sv
// tp_dr_rx: two-phase dual-rail token receiver with a 2-deep output FIFO.
// Each input rail passes through a SYNC_STAGES-deep synchronizer. A token
// is complete when every bit pair has exactly one rail differing from the
// phase of the last consumed token. A complete token must be seen unchanged
// for two consecutive cycles (IDLE -> STABLE -> CAPT) before it is captured.
// On capture the decoded word is pushed, the phase register is updated and
// ack_o toggles once.
// Ports:
//   clk      in   sole clock
//   rst      in   synchronous active-high reset
//   in       in   [WIDTH-1:0][RAIL_NUM-1:0] dual-rail token (rail1 = '1')
//   ready_i  in   consumer accepts data_o when valid_o && ready_i
//   ack_o    out  two-phase acknowledge, one toggle per consumed token
//   data_o   out  decoded word at the FIFO head
//   valid_o  out  FIFO holds at least one word
//   err_o    out  sticky both-rails protocol error (TP_DR_RX_ERR_EN only)
// Optional feature macro: TP_DR_RX_ERR_EN
module tp_dr_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int RAIL_NUM    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]   in,
    input  logic                             ready_i,
    output logic                             ack_o,
    output logic [WIDTH-1:0]                 data_o,
    output logic                             valid_o
`ifdef TP_DR_RX_ERR_EN
    ,
    output logic                             err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STABLE = 2'd1,
        CAPT   = 2'd2
    } state_t;

    state_t                           r_state;
    logic [WIDTH-1:0][RAIL_NUM-1:0]   r_sync [SYNC_STAGES];
    logic [WIDTH-1:0][RAIL_NUM-1:0]   r_ph;
    logic [WIDTH-1:0][RAIL_NUM-1:0]   r_lat;
    logic                             r_ack;

    logic [WIDTH-1:0]                 r_mem [2];
    logic                             r_wp;
    logic                             r_rp;
    logic [1:0]                       r_cnt;

    logic [WIDTH-1:0][RAIL_NUM-1:0]   w_sin;
    logic [WIDTH-1:0][RAIL_NUM-1:0]   w_diff;
    logic [WIDTH-1:0]                 w_pair_ok;
    logic [WIDTH-1:0]                 w_word;
    logic                             w_tok_ok;
    logic                             w_room;
    logic                             w_halt;
    logic                             w_push;
    logic                             w_pop;

    // Synchronizer chain; only the last stage feeds detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sin  = r_sync[SYNC_STAGES-1];
    assign w_diff = w_sin ^ r_ph;

    // A pair with both rails changed is never complete.
    always_comb begin
        w_pair_ok = '0;
        w_word    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pair_ok[i] = w_diff[i][0] ^ w_diff[i][1];
            w_word[i]    = w_diff[i][1];
        end
    end

    assign w_tok_ok = &w_pair_ok;
    // Eligibility looks only at the registered count, so a full FIFO
    // withholds the ack and stalls the upstream.
    assign w_room   = (r_cnt != 2'd2);
    assign w_push   = (r_state == STABLE) && w_tok_ok
                      && (w_diff == r_lat) && !w_halt;
    assign w_pop    = (r_cnt != 2'd0) && ready_i;

`ifdef TP_DR_RX_ERR_EN
    logic [WIDTH-1:0] w_pair_bad;
    logic             r_err;

    always_comb begin
        w_pair_bad = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pair_bad[i] = w_diff[i][0] & w_diff[i][1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_pair_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err_o  = r_err;
    assign w_halt = r_err;
`else
    assign w_halt = 1'b0;
`endif

    // Detection FSM: a token must hold identical for two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lat   <= '0;
            r_ph    <= '0;
            r_ack   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_tok_ok && w_room && !w_halt) begin
                        r_state <= STABLE;
                        r_lat   <= w_diff;
                    end
                end
                STABLE: begin
                    if (w_push) begin
                        r_state <= CAPT;
                        r_ph    <= w_sin;
                        r_ack   <= ~r_ack;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CAPT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Two-entry output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                r_mem[k] <= '0;
            end
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_word;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    assign ack_o   = r_ack;
    assign data_o  = r_mem[r_rp];
    assign valid_o = (r_cnt != 2'd0);

endmodule

// File: tb/tb_tp_dr_rx.sv
// tb_tp_dr_rx: bench for tp_dr_rx with WIDTH=4, SYNC_STAGES=2.
// Upstream rail model, table of counter tokens and a word scoreboard.
module tb_tp_dr_rx;

    localparam int W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ready_i = 1'b0;
    logic [W-1:0][1:0]  in_r;
    logic               ack_o;
    logic [W-1:0]       data_o;
    logic               valid_o;
`ifdef TP_DR_RX_ERR_EN
    logic               err_o;
`endif

    tp_dr_rx #(
        .WIDTH(W),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in_r),
        .ready_i(ready_i),
        .ack_o(ack_o),
        .data_o(data_o),
        .valid_o(valid_o)
`ifdef TP_DR_RX_ERR_EN
        ,
        .err_o(err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tok;
        logic [3:0] exp;
    } vec_t;

    vec_t              tbl [17];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                n_ack = 0;
    logic              prev_ack = 1'b0;
    logic              last_ack = 1'b0;
    logic [3:0]        q [$];
    logic [W-1:0][1:0] up;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Upstream: toggle the rail selected by each masked bit of v.
    task automatic send(input logic [3:0] v, input logic [3:0] m);
        for (int i = 0; i < W; i++) begin
            if (m[i]) up[i][v[i]] = ~up[i][v[i]];
        end
        in_r = up;
    endtask

    task automatic wait_ack(input string nm);
        bit got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(posedge clk);
            #1;
            if (ack_o != last_ack) got = 1'b1;
        end
        last_ack = ack_o;
        check(nm, int'(got), 1);
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 30 && q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check(nm, q.size(), 0);
    endtask

    // Output monitor: pops and compares on every accepted word.
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = ack_o;
        end else begin
            if (ack_o != prev_ack) n_ack++;
            prev_ack = ack_o;
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    check("pop_data", int'(data_o), int'(q.pop_front()));
                end
            end
        end
    end

    initial begin
        int base;
        for (int k = 0; k < 16; k++) begin
            tbl[k].tok = 4'(k);
            tbl[k].exp = 4'(k);
        end
        tbl[16].tok = 4'h0;
        tbl[16].exp = 4'h0;

        up   = '0;
        in_r = '0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(valid_o), 0);
        check("rst_ack", int'(ack_o), 0);
        check("rst_data", int'(data_o), 0);
        check("rst_state", int'(dut.r_state), 0);
        rst = 1'b0;

        // Latency: token 0x5 driven just after edge 0.
        @(posedge clk);
        #1;
        send(4'h5, 4'hF);
        q.push_back(4'h5);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                check("lat_e3_state", int'(dut.r_state), 1);
                check("lat_e3_valid", int'(valid_o), 0);
                check("lat_e3_ack", int'(ack_o), 0);
            end
            if (e == 4) begin
                check("lat_e4_state", int'(dut.r_state), 2);
                check("lat_e4_valid", int'(valid_o), 1);
                check("lat_e4_ack", int'(ack_o), 1);
                check("lat_e4_data", int'(data_o), 5);
            end
        end
        last_ack = ack_o;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold_data", int'(data_o), 5);
            check("hold_valid", int'(valid_o), 1);
        end
        ready_i = 1'b1;
        drain("drain_lat");

        // Counter sequence 0..F then wrap to 0.
        base = n_ack;
        for (int k = 0; k < 17; k++) begin
            send(tbl[k].tok, 4'hF);
            q.push_back(tbl[k].exp);
            wait_ack($sformatf("cnt_ack_%0d", k));
        end
        drain("drain_cnt");
        check("cnt_ack_total", n_ack - base, 17);

        // Backpressure: two buffered, third stalls.
        ready_i = 1'b0;
        base = n_ack;
        send(4'hA, 4'hF);
        q.push_back(4'hA);
        wait_ack("bp_ack_a");
        send(4'h3, 4'hF);
        q.push_back(4'h3);
        wait_ack("bp_ack_b");
        send(4'hC, 4'hF);
        q.push_back(4'hC);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_ack", int'(ack_o), int'(last_ack));
        check("bp_ack_cnt", n_ack - base, 2);
        check("bp_valid", int'(valid_o), 1);
        check("bp_head", int'(data_o), 4'hA);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        wait_ack("bp_ack_c");
        ready_i = 1'b1;
        drain("drain_bp");
        check("bp_ack_cnt3", n_ack - base, 3);

        // Skewed token: b3 arrives one cycle late.
        base = n_ack;
        send(4'h9, 4'b0111);
        q.push_back(4'h9);
        @(posedge clk);
        #1;
        send(4'h9, 4'b1000);
        wait_ack("skew_ack");
        repeat (10) @(posedge clk);
        #1;
        check("skew_ack_cnt", n_ack - base, 1);
        drain("drain_skew");

        // Reset while in STABLE with one word buffered.
        ready_i = 1'b0;
        send(4'h9, 4'hF);
        q.push_back(4'h9);
        wait_ack("rs_ack_x");
        check("rs_buffered", int'(valid_o), 1);
        send(4'h6, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("rs_in_stable", int'(dut.r_state), 1);
        rst  = 1'b1;
        up   = '0;
        in_r = '0;
        q.delete();
        @(posedge clk);
        #1;
        check("rs_valid", int'(valid_o), 0);
        check("rs_ack", int'(ack_o), 0);
        check("rs_state", int'(dut.r_state), 0);
        rst      = 1'b0;
        last_ack = ack_o;
        ready_i  = 1'b1;
        send(4'h3, 4'hF);
        q.push_back(4'h3);
        wait_ack("rs_ack_3");
        drain("drain_rs");

`ifdef TP_DR_RX_ERR_EN
        // Both rails of b0 toggle: sticky error, no ack.
        base = n_ack;
        @(posedge clk);
        #1;
        up[0] = ~up[0];
        in_r  = up;
        repeat (2) @(posedge clk);
        #1;
        check("err_e2", int'(err_o), 0);
        @(posedge clk);
        #1;
        check("err_e3", int'(err_o), 1);
        repeat (10) @(posedge clk);
        #1;
        check("err_sticky", int'(err_o), 1);
        check("err_no_ack", n_ack - base, 0);
        rst  = 1'b1;
        up   = '0;
        in_r = '0;
        @(posedge clk);
        #1;
        check("err_clear", int'(err_o), 0);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
